lcd_host_seq: RTL and testbench
===============================

Name: lcd_host_seq

Overview:
- Host-side initiator for the team's 8x8-pixel LCD controller command interface.
- Accepts one operation at a time from a local request port and drives cmd/cmd_valid/datain under the controller's busy handshake.
- For LOAD it streams 64 pixels from a synchronous image ROM.
- Captures the 16-pixel display burst that follows every command into a readable buffer, with a checksum and error flags.

Parameters:
- TIMEOUT, 256, max cycles busy may stay high after command acceptance before err_timeout is set.
- CNT_W, 9, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- op_valid  input  1  operation request valid
- op_cmd  input  3  operation code; same encoding as lcd_cmd
- op_ready  output  1  high only in IDLE; op accepted on the edge where op_valid && op_ready
- img_addr  output  6  image ROM address, row-major (y*8+x)
- img_data  input  8  ROM read data, valid the cycle after img_addr is presented
- lcd_cmd  output  3  to controller cmd: 0 reflash, 1 load, 2 zoom-in, 3 zoom-fit, 4 right, 5 left, 6 up, 7 down
- lcd_cmd_valid  output  1  to controller cmd_valid
- lcd_datain  output  8  to controller datain
- lcd_busy  input  1  from controller busy
- lcd_dataout  input  8  from controller dataout
- lcd_output_valid  input  1  from controller output_valid
- cap_addr  input  4  capture buffer read address
- cap_data  output  8  capture buffer data; combinational read
- frame_done  output  1  one-cycle pulse when a command completes
- frame_sum  output  12  sum of the 16 captured pixels; held until the next frame_done
- err_timeout  output  1  sticky; cleared only by reset
- err_count  output  1  sticky; set if a frame completes with capture count != 16

Behaviour:
- Reset values:
  - All outputs 0, including op_ready. op_ready rises the first edge after reset release.
  - FSM enters IDLE; capture buffer contents undefined.
- Registered outputs: lcd_cmd, lcd_cmd_valid, lcd_datain, img_addr.
- Controller handshake:
  - A command is accepted on the edge where lcd_cmd_valid=1 and lcd_busy=0.
  - Host deasserts lcd_cmd_valid on that same edge.
  - lcd_cmd_valid is never high for more than one cycle.
- FSM states:
  - IDLE: op_ready=1. On op accept, latch op_cmd; if op_cmd=1 drive img_addr=0. Go ISSUE.
  - ISSUE:
    - Drive lcd_cmd=latched op and lcd_cmd_valid=1 while lcd_busy=0; hold cmd_valid low while busy=1.
    - On acceptance: clear capture count, clear watchdog. If op=1 go LOAD, else go WAIT.
    - On the LOAD acceptance edge: lcd_datain<=img_data (pixel 0), img_addr<=1.
  - LOAD:
    - Each edge: lcd_datain<=img_data and img_addr increments. Pixel k sits on lcd_datain during the k-th cycle after acceptance, k=0..63, back-to-back with no gaps.
    - After pixel 63 is driven: go WAIT; lcd_datain holds the last value.
  - WAIT: on lcd_busy falling (registered busy=1, current busy=0), pulse frame_done, update frame_sum, go IDLE.
- Capture:
  - Active in every state.
  - On each edge with lcd_output_valid=1 and count<16: buf[count]<=lcd_dataout, accumulate sum, count++.
  - Valid beats beyond 16 are ignored.
  - frame_done coincides with err_count being set when count != 16.
- Watchdog:
  - Counts cycles from acceptance while in LOAD or WAIT.
  - Reaching TIMEOUT: set err_timeout, force IDLE without frame_done.
- Arithmetic: frame_sum is 12-bit unsigned; 16*255=4080 fits, so no wrap.
- Op with op_valid=1 outside IDLE: ignored, not queued.
- Reset mid-operation: immediate return to reset values. Any partially loaded controller image is the controller's concern; the host only guarantees lcd_cmd_valid=0.

Test Plan:
- LOAD with ROM[i]=i, against a behavioural controller model.
  - Required: pixel k on lcd_datain exactly k+1 cycles after the acceptance edge; 16 captured pixels equal 0,2,4,6,16,18,20,22,32,34,36,38,48,50,52,54.
  - Required: frame_sum=432; frame_done pulses once; no error flags set.
- LOAD, then zoom-in(2), then right(4) twice.
  - Required after final frame: cap_data[0]=ROM[2*8+4]=20, cap_data[15]=ROM[5*8+7]=47; frame_sum=536.
- Controller holds busy high for 10 extra cycles before accepting a command.
  - Required: lcd_cmd_valid stays low until busy=0, then is high for exactly 1 cycle.
- Model asserts busy forever after accepting a command, TIMEOUT=256.
  - Required: err_timeout=1 at 256 cycles after acceptance; FSM back in IDLE; no frame_done.
- Model emits only 15 output_valid beats.
  - Required: frame_done pulses with err_count=1 in the same cycle.
- Reset asserted during LOAD at pixel 30.
  - Required: all outputs 0 asynchronously; the next op runs a clean LOAD starting from img_addr=0.

Source files
------------

// File: rtl/lcd_host_seq.sv
// Host-side sequencer for the 8x8 LCD controller command port.
// Takes one op at a time, issues it under the busy handshake, streams the
// 64-pixel image from ROM for LOAD, and captures the 16-pixel display burst
// that follows every command together with its checksum and error flags.
//
// The ROM address register is img_addr itself: img_data is the ROM word for
// the address currently held on img_addr, one cycle after it was clocked.
module lcd_host_seq #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9    // watchdog width; 2**CNT_W must exceed TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_cmd,
    output logic        op_ready,
    output logic [5:0]  img_addr,
    input  logic [7:0]  img_data,
    output logic [2:0]  lcd_cmd,
    output logic        lcd_cmd_valid,
    output logic [7:0]  lcd_datain,
    input  logic        lcd_busy,
    input  logic [7:0]  lcd_dataout,
    input  logic        lcd_output_valid,
    input  logic [3:0]  cap_addr,
    output logic [7:0]  cap_data,
    output logic        frame_done,
    output logic [11:0] frame_sum,
    output logic        err_timeout,
    output logic        err_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_LOAD,
        S_WAIT
    } state_t;

    localparam logic [2:0]       CMD_LOAD = 3'd1;
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT - 1);

    state_t           state, state_n;
    logic [2:0]       cmd_n;
    logic             cmd_valid_n;
    logic [7:0]       datain_n;
    logic [5:0]       addr_n;
    logic             done_n;
    logic             tmo_n;

    logic             busy_q;
    logic [4:0]       cap_cnt, cap_cnt_nxt;
    logic [11:0]      cap_sum, cap_sum_nxt;
    logic [7:0]       cap_buf [16];
    logic [CNT_W-1:0] wd;

    logic op_acc, cmd_acc, busy_fall, cap_take, wd_hit;

    assign op_acc    = op_valid && op_ready;
    assign cmd_acc   = (state == S_ISSUE) && lcd_cmd_valid && !lcd_busy;
    assign busy_fall = busy_q && !lcd_busy;
    // Only the first 16 beats of a burst are kept; cap_cnt[4] marks "full".
    assign cap_take  = lcd_output_valid && !cap_cnt[4];
    assign wd_hit    = ((state == S_LOAD) || (state == S_WAIT)) && (wd == WD_LAST);

    // Include the beat landing on this edge so frame completion sees it.
    assign cap_cnt_nxt = cap_take ? cap_cnt + 5'd1 : cap_cnt;
    assign cap_sum_nxt = cap_take ? cap_sum + 12'(lcd_dataout) : cap_sum;

    assign cap_data = cap_buf[cap_addr];

    // Next-state and next values of all registered outputs.
    always_comb begin
        state_n     = state;
        cmd_n       = lcd_cmd;
        cmd_valid_n = 1'b0;
        datain_n    = lcd_datain;
        addr_n      = img_addr;
        done_n      = 1'b0;
        tmo_n       = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_acc) begin
                    cmd_n = op_cmd;
                    if (op_cmd == CMD_LOAD) addr_n = 6'd0;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_acc) begin
                    if (lcd_cmd == CMD_LOAD) begin
                        datain_n = img_data;   // pixel 0
                        addr_n   = 6'd1;
                        state_n  = S_LOAD;
                    end else begin
                        state_n  = S_WAIT;
                    end
                end else begin
                    // Re-offer only while the controller is free, so valid
                    // never lingers across a busy cycle.
                    cmd_valid_n = !lcd_busy;
                end
            end
            S_LOAD: begin
                if (wd_hit) begin
                    tmo_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    datain_n = img_data;
                    if (img_addr == 6'd63) begin
                        state_n = S_WAIT;      // pixel 63 goes out on this edge
                    end else begin
                        addr_n  = img_addr + 6'd1;
                    end
                end
            end
            S_WAIT: begin
                if (busy_fall) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (wd_hit) begin
                    tmo_n   = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register and registered command-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            op_ready      <= 1'b0;
            busy_q        <= 1'b0;
            lcd_cmd       <= 3'd0;
            lcd_cmd_valid <= 1'b0;
            lcd_datain    <= 8'd0;
            img_addr      <= 6'd0;
        end else begin
            state         <= state_n;
            op_ready      <= (state_n == S_IDLE);
            busy_q        <= lcd_busy;
            lcd_cmd       <= cmd_n;
            lcd_cmd_valid <= cmd_valid_n;
            lcd_datain    <= datain_n;
            img_addr      <= addr_n;
        end
    end

    // Frame completion pulse, checksum and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_done  <= 1'b0;
            frame_sum   <= 12'd0;
            err_timeout <= 1'b0;
            err_count   <= 1'b0;
        end else begin
            frame_done <= done_n;
            if (done_n) begin
                frame_sum <= cap_sum_nxt;
                if (cap_cnt_nxt != 5'd16) err_count <= 1'b1;
            end
            if (tmo_n) err_timeout <= 1'b1;
        end
    end

    // Capture count and running sum; restarted when a command is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_cnt <= 5'd0;
            cap_sum <= 12'd0;
        end else if (cmd_acc) begin
            cap_cnt <= 5'd0;
            cap_sum <= 12'd0;
        end else begin
            cap_cnt <= cap_cnt_nxt;
            cap_sum <= cap_sum_nxt;
        end
    end

    // Capture buffer storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (cap_take && !cmd_acc) cap_buf[cap_cnt[3:0]] <= lcd_dataout;
    end

    // Watchdog: cycles since acceptance while the controller owns the op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd <= '0;
        end else if (cmd_acc) begin
            wd <= '0;
        end else if ((state == S_LOAD) || (state == S_WAIT)) begin
            wd <= wd + 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_host_seq.sv
// Bench for lcd_host_seq: behavioural 8x8 controller model, ROM[i]=i,
// scoreboards for the pixel stream and for frame results.
`timescale 1ns/1ps
module tb_lcd_host_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid = 1'b0;
    logic [2:0]  op_cmd = 3'd0;
    logic        op_ready;
    logic [5:0]  img_addr;
    logic [7:0]  img_data;
    logic [2:0]  lcd_cmd;
    logic        lcd_cmd_valid;
    logic [7:0]  lcd_datain;
    logic        lcd_busy = 1'b0;
    logic [7:0]  lcd_dataout = 8'd0;
    logic        lcd_output_valid = 1'b0;
    logic [3:0]  cap_addr = 4'd0;
    logic [7:0]  cap_data;
    logic        frame_done;
    logic [11:0] frame_sum;
    logic        err_timeout;
    logic        err_count;

    lcd_host_seq #(.TIMEOUT(256), .CNT_W(9)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_cmd(op_cmd), .op_ready(op_ready),
        .img_addr(img_addr), .img_data(img_data),
        .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid), .lcd_datain(lcd_datain),
        .lcd_busy(lcd_busy), .lcd_dataout(lcd_dataout), .lcd_output_valid(lcd_output_valid),
        .cap_addr(cap_addr), .cap_data(cap_data),
        .frame_done(frame_done), .frame_sum(frame_sum),
        .err_timeout(err_timeout), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Image ROM, ROM[i] = i; data follows the registered address.
    logic [7:0] rom [64];
    initial for (int i = 0; i < 64; i++) rom[i] = 8'(i);
    assign img_data = rom[img_addr];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct {
        logic [11:0] sum;
        logic        errc;
        logic        errt;
    } exp_t;
    exp_t       sb[$];
    logic [7:0] pix_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- controller model ----------------
    localparam int M_IDLE = 0, M_LOAD = 1, M_OUT = 2, M_HANG = 3;
    int         mode = M_IDLE;
    logic [7:0] img [64];
    int         ld = 0, beat = 0, beats = 16, hold_cnt = 0;
    bit         hang = 1'b0, zoom = 1'b0;
    int         ox = 0, oy = 0;
    logic       cv, bz;
    logic [2:0] cm;

    function automatic logic [7:0] pix(input int b);
        int i, j;
        i = b % 4;
        j = b / 4;
        if (zoom) return img[(oy + j) * 8 + ox + i];
        return img[(2 * j) * 8 + 2 * i];
    endfunction

    task automatic model_rst();
        mode = M_IDLE; lcd_busy = 1'b0; lcd_output_valid = 1'b0; lcd_dataout = 8'd0;
        hold_cnt = 0; hang = 1'b0; ld = 0; beat = 0;
    endtask

    task automatic apply(input logic [2:0] c);
        case (c)
            3'd2: begin zoom = 1'b1; ox = 2; oy = 2; end
            3'd3: zoom = 1'b0;
            3'd4: if (ox < 4) ox++;
            3'd5: if (ox > 0) ox--;
            3'd6: if (oy > 0) oy--;
            3'd7: if (oy < 4) oy++;
            default: ;
        endcase
    endtask

    task automatic model_step();
        lcd_output_valid = 1'b0;
        case (mode)
            M_IDLE: begin
                if (cv && !bz) begin
                    lcd_busy = 1'b1;
                    if (hang) mode = M_HANG;
                    else if (cm == 3'd1) begin mode = M_LOAD; ld = 0; zoom = 1'b0; end
                    else begin apply(cm); mode = M_OUT; beat = 0; end
                end else begin
                    lcd_busy = (hold_cnt != 0);
                    if (hold_cnt > 0) hold_cnt--;
                end
            end
            M_LOAD: if (ld == 64) begin mode = M_OUT; beat = 0; end
            M_OUT: begin
                if (beat < beats) begin
                    lcd_output_valid = 1'b1;
                    lcd_dataout = pix(beat);
                    beat++;
                end else begin
                    lcd_busy = 1'b0;
                    mode = M_IDLE;
                end
            end
            default: ;
        endcase
    endtask

    // Sample DUT at negedge (pixel stream scoreboard), act just after posedge.
    initial begin
        logic [31:0] exp_p;
        forever begin
            @(negedge clk);
            if (reset) model_rst();
            else begin
                cv = lcd_cmd_valid; cm = lcd_cmd; bz = lcd_busy;
                if (mode == M_LOAD && ld < 64) begin
                    exp_p = (pix_q.size() != 0) ? 32'(pix_q.pop_front()) : 32'bx;
                    chk("pixel", 32'(lcd_datain), exp_p);
                    img[ld] = lcd_datain;
                    ld++;
                end
                @(posedge clk); #1;
                if (!reset) model_step();
            end
        end
    end

    // Frame result scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && frame_done) begin
            done_cnt++;
            if (sb.size() == 0) chk("spurious_done", 32'(frame_done), 32'd0);
            else begin
                e = sb.pop_front();
                chk("frame_sum", 32'(frame_sum), 32'(e.sum));
                chk("err_count", 32'(err_count), 32'(e.errc));
                chk("err_timeout", 32'(err_timeout), 32'(e.errt));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_frame(input int sum, input bit errc, input bit errt);
        exp_t e;
        e.sum = 12'(sum); e.errc = errc; e.errt = errt;
        sb.push_back(e);
    endtask

    task automatic push_pixels();
        for (int i = 0; i < 64; i++) pix_q.push_back(8'(i));
    endtask

    task automatic reset_dut();
        reset = 1'b1; #1;
        chk("rst_op_ready", 32'(op_ready), 32'd0);
        chk("rst_img_addr", 32'(img_addr), 32'd0);
        chk("rst_lcd_cmd", 32'(lcd_cmd), 32'd0);
        chk("rst_cmd_valid", 32'(lcd_cmd_valid), 32'd0);
        chk("rst_datain", 32'(lcd_datain), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_sum", 32'(frame_sum), 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        sb.delete(); pix_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0; #1;
        chk("ready_after_release", 32'(op_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_first_edge", 32'(op_ready), 32'd1);
    endtask

    task automatic issue(input logic [2:0] c);
        int n = 0;
        @(negedge clk);
        while (!op_ready && n < 400) begin @(negedge clk); n++; end
        chk("op_ready_wait", 32'(op_ready), 32'd1);
        op_valid = 1'b1; op_cmd = c;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_frame(input int target);
        int n = 0;
        while (done_cnt < target && n < 2000) begin @(negedge clk); n++; end
        chk("frame_wait", 32'(done_cnt >= target), 32'd1);
        repeat (3) @(negedge clk);
        chk("done_once", 32'(done_cnt), 32'(target));
    endtask

    task automatic chk_cap(input int a, input int exp);
        cap_addr = 4'(a); #1;
        chk("cap_data", 32'(cap_data), 32'(exp));
    endtask

    int fit_exp [16] = '{0, 2, 4, 6, 16, 18, 20, 22, 32, 34, 36, 38, 48, 50, 52, 54};

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit reached");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n, n_bad, n_cv, hold_len, gap, d0;
        bit first, found;

        reset_dut();

        // LOAD, fit view
        push_frame(432, 1'b0, 1'b0); push_pixels();
        issue(3'd1);
        wait_frame(1);
        for (int i = 0; i < 16; i++) chk_cap(i, fit_exp[i]);

        // zoom-in then right twice
        push_frame(504, 1'b0, 1'b0); issue(3'd2); wait_frame(2);
        push_frame(520, 1'b0, 1'b0); issue(3'd4); wait_frame(3);
        push_frame(536, 1'b0, 1'b0); issue(3'd4); wait_frame(4);
        chk_cap(0, 20); chk_cap(5, 29); chk_cap(15, 47);

        // controller busy for 10 cycles before taking a reflash
        @(negedge clk);
        hold_cnt = 10;
        push_frame(536, 1'b0, 1'b0);
        issue(3'd0);
        n = 0; n_bad = 0; n_cv = 0; hold_len = 0; gap = 0; first = 1'b0;
        while (done_cnt < 5 && n < 300) begin
            if (lcd_cmd_valid) begin
                n_cv++; first = 1'b1;
                if (lcd_busy) n_bad++;
            end else if (!first) begin
                if (lcd_busy) hold_len++;
                else gap++;
            end
            @(negedge clk); n++;
        end
        chk("cv_while_busy", 32'(n_bad), 32'd0);
        chk("cv_cycles", 32'(n_cv), 32'd1);
        chk("busy_hold_seen", 32'(hold_len), 32'd9);
        chk("cv_after_busy_gap", 32'(gap), 32'd1);
        wait_frame(5);

        // short burst: 15 beats
        beats = 15;
        push_frame(378, 1'b1, 1'b0);
        issue(3'd3);
        wait_frame(6);
        beats = 16;

        // controller never releases busy
        hang = 1'b1;
        issue(3'd0);
        found = 1'b0; n = 0;
        while (!found && n < 50) begin
            if (lcd_cmd_valid && !lcd_busy) found = 1'b1;
            else begin @(negedge clk); n++; end
        end
        chk("timeout_cv_seen", 32'(found), 32'd1);
        d0 = done_cnt;
        repeat (256) @(negedge clk);
        chk("tmo_before", 32'(err_timeout), 32'd0);
        chk("tmo_ready_before", 32'(op_ready), 32'd0);
        @(negedge clk);
        chk("tmo_at_256", 32'(err_timeout), 32'd1);
        chk("tmo_idle", 32'(op_ready), 32'd1);
        chk("tmo_no_done", 32'(done_cnt), 32'(d0));

        // reset in the middle of a LOAD
        reset_dut();
        push_pixels();
        issue(3'd1);
        n = 0;
        while (lcd_datain != 8'd30 && n < 200) begin @(negedge clk); n++; end
        chk("reached_pixel30", 32'(lcd_datain), 32'd30);
        #2;
        reset_dut();
        push_frame(432, 1'b0, 1'b0); push_pixels();
        issue(3'd1);
        chk("clean_load_addr", 32'(img_addr), 32'd0);
        wait_frame(d0 + 1);
        chk_cap(0, 0); chk_cap(15, 54);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
